cnt_arbiter: RTL
================

# cnt_arbiter

Shares one down-counting datapath between NREQ requesters, each asking for a timed run of a programmable length. Arbitration is round-robin. The block grants the counter to one requester, loads that requester's length and counts down to zero. It then signals done to the owner and releases the counter. It sits between the requesting blocks and the shared counter/adder datapath.

## Interface
- NREQ, 4: number of requesters, 2..8
- W, 8: counter and length width
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset; 0 = reset asserted
- req  in  NREQ  per-requester request; held high until done or abort
- len  in  NREQ*W  per-requester run length; slice i = len[i*W +: W]; sampled in LOAD only
- gnt  out  NREQ  one-hot grant; all zero when idle
- done  out  NREQ  one-cycle completion pulse to the owner
- busy  out  1  high in LOAD, RUN and DONE
- owner  out  $clog2(NREQ)  index of the current or last owner
- cnt  out  W  remaining count

## Operation
- Reset values: state=IDLE, gnt=0, done=0, busy=0, owner=NREQ-1 (so requester 0 has first priority), cnt=0.
- IDLE: if any req is high, pick the first set bit searching upward from owner+1, modulo NREQ. Set owner to that index, set gnt[owner], go to LOAD. Otherwise stay in IDLE.
- LOAD: cnt <= len[owner].
  - If that length is 0, go straight to DONE.
  - Otherwise go to RUN.
- RUN: cnt <= cnt-1 each cycle.
  - When cnt==1, the next state is DONE, with cnt=0.
  - cnt never wraps below 0.
- DONE: done[owner]=1 for exactly this cycle. Next state is IDLE, and gnt clears on entry to IDLE.
- Abort: if req[owner] is low in LOAD or RUN, go to IDLE next cycle.
  - No done pulse is issued.
  - cnt holds its value.
  - owner keeps the aborted index, so fairness advances past it.
- req bits of non-owners are ignored while busy. They are arbitrated on the next IDLE cycle.
- A req that drops in DONE does not matter: done still pulses.
- Asserting rst at any time returns everything to the reset values immediately. No done is emitted for an interrupted run.

## Timing
- req sampled at edge 0 (IDLE) -> gnt/busy high after edge 0 -> LOAD.
- Edge 1: cnt=len.
- Edges 2..len+1: one decrement per edge.
- DONE is the cycle after edge len+1; done falls after edge len+2.
- Request-to-done latency is len+2 edges; for len=0 it is 2 edges.
- There is exactly one IDLE cycle between consecutive grants. Peak throughput is one run per len+3 cycles.
- gnt, busy, owner, cnt and done are all registered outputs with no combinational path from inputs.

## Structure
- Package cnt_arb_pkg holds:
  - state enum {IDLE, LOAD, RUN, DONE}, 2-bit encoding
  - default constants NREQ_DEF=4 and W_DEF=8
  - the function idx_w(NREQ) = $clog2(NREQ)
- Sub-module rr_pick is purely combinational.
  - Inputs: req vector and last index.
  - Outputs: one-hot pick, its index, and a valid flag.
  - It is instantiated once in cnt_arbiter.
- The counter, FSM and output registers live in cnt_arbiter.

## Test plan
- Reset mid-run: start req[0] with len=10, pull rst low after 4 RUN cycles -> all outputs return to reset values at once; no done; a fresh req[0] restarts from len=10.
- Single requester: req[2]=1, len[2]=5 -> gnt=4'b0100 one edge later; cnt goes 5,4,3,2,1,0; done[2] pulses exactly 7 edges after the request is sampled; busy low one edge later.
- Zero length: req[1]=1, len[1]=0 -> LOAD then DONE; done[1] 2 edges after the request; cnt=0 throughout.
- Round-robin fairness: all four req held high, every len=1 -> grant order 0,1,2,3,0; each done spaced 4 cycles apart; no requester granted twice before the others.
- Abort: req[3] with len=8, drop req[3] after 3 RUN cycles -> IDLE next edge, cnt holds at 5, no done; pending req[0] is granted next because the search starts at owner+1 wrapping to 0.
- Boundary length: len=8'hFF -> exactly 255 decrements, no wrap; done at edge 257.

Source files
------------

// File: rtl/cnt_arb_pkg.sv
// Shared types, defaults and helpers for the counter arbiter.
//   state_e  : arbiter FSM states (2-bit encoding)
//   NREQ_DEF : default requester count
//   W_DEF    : default counter/length width
//   idx_w()  : width of a requester index
package cnt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned W_DEF    = 8;

    function automatic int unsigned idx_w(input int unsigned nreq);
        return $clog2(nreq);
    endfunction

endpackage

// File: rtl/cnt_arbiter_if.sv
// Bus between the requesting blocks and the counter arbiter.
//   req   : per-requester request (requester -> arbiter)
//   len   : per-requester run length, slice i = len[i*W +: W]
//   gnt   : one-hot grant
//   done  : one-cycle completion pulse to the owner
//   busy  : arbiter is in LOAD, RUN or DONE
//   owner : index of the current or last owner
//   cnt   : remaining count
// master = requester side, slave = arbiter side.
interface cnt_arb_if
    import cnt_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned W    = W_DEF
) ();

    localparam int unsigned IW = idx_w(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] len;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [IW-1:0]     owner;
    logic [W-1:0]      cnt;

    modport master (
        output req, len,
        input  gnt, done, busy, owner, cnt
    );

    modport slave (
        input  req, len,
        output gnt, done, busy, owner, cnt
    );

endinterface

// File: rtl/cnt_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   last  : index of the previous owner; search starts at last+1
//   pick  : one-hot selected requester
//   idx   : index of the selected requester (last when none)
//   valid : at least one request is set
module rr_pick
    import cnt_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    int unsigned cand;

    always_comb begin
        pick  = '0;
        idx   = last;
        valid = 1'b0;
        cand  = 0;
        // Walk from the farthest candidate to the nearest so the nearest set bit
        // after last wins by overwriting earlier hits.
        for (int unsigned k = NREQ; k >= 1; k--) begin
            cand = (32'(last) + k) % NREQ;
            if (req[cand[IW-1:0]]) begin
                pick               = '0;
                pick[cand[IW-1:0]] = 1'b1;
                idx                = cand[IW-1:0];
                valid              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_arbiter.sv
// Round-robin arbiter sharing one down counter between NREQ requesters.
// The winner's length is loaded, counted down to zero, then done pulses to
// the owner for one cycle and the counter is released.
//   clk : clock, all state on posedge
//   rst : asynchronous active-low reset
//   bus : cnt_arb_if slave (req/len in; gnt/done/busy/owner/cnt out, all registered)
module cnt_arbiter
    import cnt_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned W    = W_DEF
) (
    input  logic  clk,
    input  logic  rst,
    cnt_arb_if.slave bus
);

    localparam int unsigned IW = idx_w(NREQ);
    // Last owner resets to NREQ-1 so requester 0 has first priority.
    localparam logic [IW-1:0] OwnerRst = IW'(NREQ - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] pick;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic            own_req;
    logic [W-1:0]    len_sel;

    assign own_req = bus.req[owner_q];
    assign len_sel = bus.len[32'(owner_q) * W +: W];

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (bus.req),
        .last  (owner_q),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    gnt_d   = pick;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Abort leaves cnt and owner untouched.
                if (!own_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else begin
                    cnt_d   = len_sel;
                    state_d = (len_sel == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (!own_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - W'(1);
                    end
                    if (cnt_q <= W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        // done is registered, so it is raised on the edge that enters DONE.
        if (state_d == DONE) begin
            done_d[owner_q] = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OwnerRst;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;
    assign bus.cnt   = cnt_q;

endmodule
